ysyx_22050078_ifu: RTL

Instruction fetch unit for the ysyx_22050078 RV64 core. It sits between the PC unit and the decode unit (IDU). It accepts one fetch PC per transaction, issues an 8-byte-aligned read on the instruction memory port, and selects the 32-bit instruction word from the 64-bit response. It then holds the instruction, its PC and a fault flag stable until IDU accepts them. A flush input discards any fetch in progress; this is how jumps and taken branches redirect the fetch stream.

---
 rtl/ysyx_22050078_ifu.sv | 103 ++++++++++
 1 files changed

// File: rtl/ysyx_22050078_ifu.sv
// Instruction fetch unit: takes one PC, issues an 8-byte-aligned read, selects the
// 32-bit word and holds the bundle for IDU; flush discards any fetch in flight.
module ysyx_22050078_ifu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_pc_valid,
  output logic            o_pc_ready,
  input  logic            i_flush,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [63:0]     i_imem_rsp_data,
  input  logic            i_imem_rsp_err,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            fault_q;
  logic            kill;
  logic            accept;
  logic            misaligned;

  assign accept     = (state == IDLE) && i_pc_valid && !i_flush;
  assign misaligned = (i_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = misaligned ? OUT : REQ;
      REQ:  if (i_imem_req_ready) state_nxt = WAIT;
      WAIT: if (i_imem_rsp_valid) state_nxt = (kill || i_flush) ? IDLE : OUT;
      OUT:  if (i_flush || i_inst_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A flush while the request is outstanding cannot cancel it, so kill marks the
  // eventual response as one to be dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
      kill    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pc_q <= i_pc;
            if (misaligned) begin
              inst_q  <= '0;
              fault_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (i_flush) kill <= 1'b1;
        end
        WAIT: begin
          if (i_imem_rsp_valid) begin
            kill <= 1'b0;
            if (!kill && !i_flush) begin
              fault_q <= i_imem_rsp_err;
              if (i_imem_rsp_err) inst_q <= '0;
              else inst_q <= pc_q[2] ? i_imem_rsp_data[63:32] : i_imem_rsp_data[31:0];
            end
          end else if (i_flush) begin
            kill <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_pc_ready       = (state == IDLE);
    o_imem_req_valid = (state == REQ);
    o_inst_valid     = (state == OUT);
    o_imem_addr      = {pc_q[XLEN-1:3], 3'b000};
    o_inst           = inst_q;
    o_inst_pc        = pc_q;
    o_fault          = fault_q;
  end

endmodule
